fb_swap_ctrl: RTL and testbench

Parametrised frame-buffer bank with 2- or 3-way buffering. Everything is in one clock domain: writer, reader and swap logic. A writer fills the write buffer and signals frame completion. The display reader reads the read buffer and requests a swap at `frame_start`. The block replaces the fixed two-buffer framebuffer and adds triple-buffer (newest-frame-wins) mode, a writer stall handshake and an optional statistics block; clock-domain crossing is handled outside it.

---
 rtl/fb_swap_ctrl.sv | 148 ++++++++++++++
 tb/tb_fb_swap_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_ctrl.sv
// Frame-buffer bank with 2- or 3-way buffering, writer stall handshake and swap control.
// Optional statistics (drop_count, overrun) are built only when FB_STATS_EN is defined.
module fb_swap_ctrl #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned NUM_BUFS   = 2
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    input  logic                  wr_done,
    output logic                  wr_ready,
    output logic                  wr_swapped,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  frame_start,
    output logic                  rd_swapped,
    output logic [1:0]            rd_buf,
    output logic                  pending,
    output logic [15:0]           drop_count,
    output logic                  overrun
);

    localparam int unsigned DEPTH  = 32'd1 << ADDR_WIDTH;
    localparam int unsigned WORDS  = NUM_BUFS * DEPTH;
    localparam int unsigned IDX_W  = (NUM_BUFS == 3) ? 2 : 1;
    localparam int unsigned MADDR_W = IDX_W + ADDR_WIDTH;
    localparam bit          TRIPLE = (NUM_BUFS == 3);

    if (NUM_BUFS != 2 && NUM_BUFS != 3) begin : g_bad_num_bufs
        $error("fb_swap_ctrl: NUM_BUFS must be 2 or 3");
    end

    logic [1:0] r_idx, w_idx, p_idx;
    logic       pend;
    logic [1:0] r_n, w_n, p_n, tmp;
    logic       pend_n, rdy_n, wsw_n, rsw_n;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [MADDR_W-1:0]    wr_addr, rd_addr;

    assign wr_addr = {w_idx[IDX_W-1:0], waddr};
    assign rd_addr = {r_idx[IDX_W-1:0], raddr};

    // Storage: plain simple dual-port RAM, contents survive reset.
    always_ff @(posedge sys_clk) begin
        if (we && wr_ready) begin
            mem[wr_addr] <= wdata;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[rd_addr];
        end
    end

    // Role update: wr_done is applied first, frame_start then sees the updated roles.
    always_comb begin
        r_n    = r_idx;
        w_n    = w_idx;
        p_n    = p_idx;
        pend_n = pend;
        rdy_n  = wr_ready;
        wsw_n  = 1'b0;
        rsw_n  = 1'b0;
        tmp    = 2'd0;
        if (wr_done) begin
            if (TRIPLE) begin
                p_n    = w_idx;
                w_n    = p_idx;
                pend_n = 1'b1;
                wsw_n  = 1'b1;
            end else if (!pend) begin
                pend_n = 1'b1;
                rdy_n  = 1'b0;
            end
        end
        if (frame_start && pend_n) begin
            tmp = r_n;
            if (TRIPLE) begin
                r_n = p_n;
                p_n = tmp;
            end else begin
                r_n   = w_n;
                w_n   = tmp;
                rdy_n = 1'b1;
                wsw_n = 1'b1;
            end
            pend_n = 1'b0;
            rsw_n  = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_idx      <= 2'd0;
            w_idx      <= 2'd1;
            p_idx      <= 2'd2;
            pend       <= 1'b0;
            wr_ready   <= 1'b1;
            wr_swapped <= 1'b0;
            rd_swapped <= 1'b0;
        end else begin
            r_idx      <= r_n;
            w_idx      <= w_n;
            p_idx      <= p_n;
            pend       <= pend_n;
            wr_ready   <= rdy_n;
            wr_swapped <= wsw_n;
            rd_swapped <= rsw_n;
        end
    end

    assign rd_buf  = r_idx;
    assign pending = pend;

`ifdef FB_STATS_EN
    logic drop_inc, ovr_set;

    // A drop only happens in triple mode; a stall overrun only in double mode.
    assign drop_inc = wr_done && TRIPLE && pend;
    assign ovr_set  = wr_done && !TRIPLE && pend;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            drop_count <= 16'd0;
            overrun    <= 1'b0;
        end else begin
            if (drop_inc && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end
`else
    assign drop_count = 16'd0;
    assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl: one 2-buffer and one 3-buffer instance with independent stimulus.
module tb_fb_swap_ctrl;

`ifdef FB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 2-buffer instance signals
    logic        rst2 = 1'b1, we2 = 1'b0, done2 = 1'b0, fs2 = 1'b0, re2 = 1'b0;
    logic [19:0] wdata2 = '0;
    logic [3:0]  waddr2 = '0, raddr2 = '0;
    logic        wr_ready2, wr_swapped2, rd_swapped2, pending2, overrun2;
    logic [19:0] rdata2;
    logic [1:0]  rd_buf2;
    logic [15:0] drop_count2;

    // 3-buffer instance signals
    logic        rst3 = 1'b1, we3 = 1'b0, done3 = 1'b0, fs3 = 1'b0, re3 = 1'b0;
    logic [19:0] wdata3 = '0;
    logic [3:0]  waddr3 = '0, raddr3 = '0;
    logic        wr_ready3, wr_swapped3, rd_swapped3, pending3, overrun3;
    logic [19:0] rdata3;
    logic [1:0]  rd_buf3;
    logic [15:0] drop_count3;

    fb_swap_ctrl #(.DATA_WIDTH(20), .ADDR_WIDTH(4), .NUM_BUFS(2)) u2 (
        .sys_clk(clk), .rst(rst2), .wdata(wdata2), .waddr(waddr2), .we(we2),
        .wr_done(done2), .wr_ready(wr_ready2), .wr_swapped(wr_swapped2),
        .raddr(raddr2), .re(re2), .rdata(rdata2), .frame_start(fs2),
        .rd_swapped(rd_swapped2), .rd_buf(rd_buf2), .pending(pending2),
        .drop_count(drop_count2), .overrun(overrun2)
    );

    fb_swap_ctrl #(.DATA_WIDTH(20), .ADDR_WIDTH(4), .NUM_BUFS(3)) u3 (
        .sys_clk(clk), .rst(rst3), .wdata(wdata3), .waddr(waddr3), .we(we3),
        .wr_done(done3), .wr_ready(wr_ready3), .wr_swapped(wr_swapped3),
        .raddr(raddr3), .re(re3), .rdata(rdata3), .frame_start(fs3),
        .rd_swapped(rd_swapped3), .rd_buf(rd_buf3), .pending(pending3),
        .drop_count(drop_count3), .overrun(overrun3)
    );

    // One clock of stimulus on the 2-buffer instance; returns at the next falling edge.
    task automatic step2(input logic we, input logic [3:0] wa, input logic [19:0] wd,
                         input logic done, input logic fs, input logic re, input logic [3:0] ra);
        we2 = we; waddr2 = wa; wdata2 = wd; done2 = done; fs2 = fs; re2 = re; raddr2 = ra;
        @(negedge clk);
        we2 = 1'b0; done2 = 1'b0; fs2 = 1'b0; re2 = 1'b0;
    endtask

    task automatic step3(input logic we, input logic [3:0] wa, input logic [19:0] wd,
                         input logic done, input logic fs, input logic re, input logic [3:0] ra);
        we3 = we; waddr3 = wa; wdata3 = wd; done3 = done; fs3 = fs; re3 = re; raddr3 = ra;
        @(negedge clk);
        we3 = 1'b0; done3 = 1'b0; fs3 = 1'b0; re3 = 1'b0;
    endtask

    task automatic test_reset();
        rst2 = 1'b1; rst3 = 1'b1;
        @(negedge clk); @(negedge clk);
        rst2 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        checks++; if (rd_buf2 !== 2'd0) begin errors++; $display("FAIL reset_rd_buf2: got %0d exp 0", rd_buf2); end
        checks++; if (wr_ready2 !== 1'b1) begin errors++; $display("FAIL reset_wr_ready2: got %b exp 1", wr_ready2); end
        checks++; if (pending2 !== 1'b0) begin errors++; $display("FAIL reset_pending2: got %b exp 0", pending2); end
        checks++; if (rdata2 !== 20'h0) begin errors++; $display("FAIL reset_rdata2: got %h exp 0", rdata2); end
        checks++; if ({wr_swapped2, rd_swapped2} !== 2'b00) begin errors++; $display("FAIL reset_pulses2: got %b exp 00", {wr_swapped2, rd_swapped2}); end
        checks++; if ({overrun2, drop_count2} !== 17'h0) begin errors++; $display("FAIL reset_stats2: got %h exp 0", {overrun2, drop_count2}); end
        checks++; if ({rd_buf3, pending3, wr_ready3} !== 4'b0001) begin errors++; $display("FAIL reset_3buf: got %b exp 0001", {rd_buf3, pending3, wr_ready3}); end
    endtask

    task automatic test_basic_2buf();
        step2(1'b1, 4'd5, 20'h12345, 1'b0, 1'b0, 1'b0, 4'd0);
        step2(1'b0, 4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++; if ({wr_ready2, pending2, wr_swapped2} !== 3'b010) begin errors++; $display("FAIL done_2buf: got %b exp 010", {wr_ready2, pending2, wr_swapped2}); end
        step2(1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        checks++; if (rd_buf2 !== 2'd1) begin errors++; $display("FAIL fs_rd_buf2: got %0d exp 1", rd_buf2); end
        checks++; if ({wr_ready2, pending2, wr_swapped2, rd_swapped2} !== 4'b1011) begin errors++; $display("FAIL fs_flags2: got %b exp 1011", {wr_ready2, pending2, wr_swapped2, rd_swapped2}); end
        step2(1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b1, 4'd5);
        checks++; if (rdata2 !== 20'h12345) begin errors++; $display("FAIL read_basic2: got %h exp 12345", rdata2); end
        checks++; if ({wr_swapped2, rd_swapped2} !== 2'b00) begin errors++; $display("FAIL pulse_width2: got %b exp 00", {wr_swapped2, rd_swapped2}); end
        step2(1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if (rdata2 !== 20'h12345) begin errors++; $display("FAIL rdata_hold2: got %h exp 12345", rdata2); end
    endtask

    task automatic test_stall_2buf();
        // roles now r=1, w=0
        step2(1'b1, 4'd0, 20'h11111, 1'b0, 1'b0, 1'b0, 4'd0);
        step2(1'b0, 4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        step2(1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        step2(1'b1, 4'd0, 20'h22222, 1'b0, 1'b0, 1'b0, 4'd0);
        step2(1'b0, 4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        step2(1'b1, 4'd0, 20'hAAAAA, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if ({wr_ready2, pending2} !== 2'b01) begin errors++; $display("FAIL stall_state2: got %b exp 01", {wr_ready2, pending2}); end
        step2(1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        step2(1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b1, 4'd0);
        checks++; if (rdata2 !== 20'h22222) begin errors++; $display("FAIL stalled_write_dropped2: got %h exp 22222", rdata2); end
        step2(1'b0, 4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        step2(1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        step2(1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b1, 4'd0);
        checks++; if (rdata2 !== 20'h11111) begin errors++; $display("FAIL old_frame2: got %h exp 11111", rdata2); end
        checks++; if (rd_buf2 !== 2'd0) begin errors++; $display("FAIL stall_rd_buf2: got %0d exp 0", rd_buf2); end
    endtask

    task automatic test_overrun_2buf();
        step2(1'b0, 4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++; if (overrun2 !== 1'b0) begin errors++; $display("FAIL overrun_early2: got %b exp 0", overrun2); end
        step2(1'b0, 4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++; if (overrun2 !== STATS) begin errors++; $display("FAIL overrun_set2: got %b exp %b", overrun2, STATS); end
        checks++; if (drop_count2 !== 16'd0) begin errors++; $display("FAIL drop_2buf: got %0d exp 0", drop_count2); end
        checks++; if ({wr_ready2, pending2} !== 2'b01) begin errors++; $display("FAIL overrun_state2: got %b exp 01", {wr_ready2, pending2}); end
        step2(1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        checks++; if ({rd_buf2, overrun2} !== {2'd1, STATS}) begin errors++; $display("FAIL overrun_sticky2: got %b exp %b", {rd_buf2, overrun2}, {2'd1, STATS}); end
    endtask

    task automatic test_simultaneous_2buf();
        rst2 = 1'b1; @(negedge clk); rst2 = 1'b0;
        checks++; if (overrun2 !== 1'b0) begin errors++; $display("FAIL overrun_reset2: got %b exp 0", overrun2); end
        step2(1'b0, 4'd0, 20'h0, 1'b1, 1'b1, 1'b0, 4'd0);
        checks++; if (rd_buf2 !== 2'd1) begin errors++; $display("FAIL simul_rd_buf2: got %0d exp 1", rd_buf2); end
        checks++; if ({wr_ready2, pending2, rd_swapped2, wr_swapped2} !== 4'b1011) begin errors++; $display("FAIL simul_flags2: got %b exp 1011", {wr_ready2, pending2, rd_swapped2, wr_swapped2}); end
        step2(1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if ({rd_swapped2, wr_swapped2} !== 2'b00) begin errors++; $display("FAIL simul_pulse_end2: got %b exp 00", {rd_swapped2, wr_swapped2}); end
    endtask

    task automatic test_triple();
        // reset roles r=0, w=1, p=2
        step3(1'b1, 4'd3, 20'h0000A, 1'b0, 1'b0, 1'b0, 4'd0);
        step3(1'b0, 4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++; if ({pending3, wr_ready3, wr_swapped3} !== 3'b111) begin errors++; $display("FAIL tri_done1: got %b exp 111", {pending3, wr_ready3, wr_swapped3}); end
        checks++; if (drop_count3 !== 16'd0) begin errors++; $display("FAIL tri_drop1: got %0d exp 0", drop_count3); end
        step3(1'b1, 4'd3, 20'h0000B, 1'b0, 1'b0, 1'b0, 4'd0);
        step3(1'b0, 4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        step3(1'b1, 4'd3, 20'h0000C, 1'b0, 1'b0, 1'b0, 4'd0);
        step3(1'b0, 4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++; if (drop_count3 !== (STATS ? 16'd2 : 16'd0)) begin errors++; $display("FAIL tri_drop3: got %0d exp %0d", drop_count3, STATS ? 2 : 0); end
        checks++; if ({pending3, wr_ready3, wr_swapped3, rd_buf3} !== 5'b11100) begin errors++; $display("FAIL tri_state3: got %b exp 11100", {pending3, wr_ready3, wr_swapped3, rd_buf3}); end
        step3(1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        checks++; if ({rd_buf3, rd_swapped3, wr_swapped3, pending3} !== 5'b01100) begin errors++; $display("FAIL tri_fs: got %b exp 01100", {rd_buf3, rd_swapped3, wr_swapped3, pending3}); end
        step3(1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b1, 4'd3);
        checks++; if (rdata3 !== 20'h0000C) begin errors++; $display("FAIL tri_newest: got %h exp 0000c", rdata3); end
        step3(1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        checks++; if ({rd_buf3, rd_swapped3} !== 3'b010) begin errors++; $display("FAIL tri_fs_idle: got %b exp 010", {rd_buf3, rd_swapped3}); end
    endtask

    task automatic test_reset_mid_3buf();
        // roles now r=1, w=2, p=0
        step3(1'b1, 4'd3, 20'h0000D, 1'b0, 1'b0, 1'b0, 4'd0);
        step3(1'b0, 4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++; if (pending3 !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b exp 1", pending3); end
        we3 = 1'b1; waddr3 = 4'd7; wdata3 = 20'h77777; rst3 = 1'b1;
        @(negedge clk);
        we3 = 1'b0; rst3 = 1'b0;
        checks++; if ({rd_buf3, pending3, wr_ready3} !== 4'b0001) begin errors++; $display("FAIL mid_reset_roles: got %b exp 0001", {rd_buf3, pending3, wr_ready3}); end
        checks++; if (drop_count3 !== 16'd0) begin errors++; $display("FAIL mid_reset_drop: got %0d exp 0", drop_count3); end
        // buffer 1 still holds frame C; bring it to display via p=1
        step3(1'b0, 4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        step3(1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        step3(1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b1, 4'd3);
        checks++; if ({rd_buf3, rdata3} !== {2'd1, 20'h0000C}) begin errors++; $display("FAIL ram_kept: got %h exp 10000c", {rd_buf3, rdata3}); end
    endtask

    initial begin
        test_reset();
        test_basic_2buf();
        test_stall_2buf();
        test_overrun_2buf();
        test_simultaneous_2buf();
        test_triple();
        test_reset_mid_3buf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
